// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the PIO instruction-memory loader path.
//   INSTR_W / ADDR_W : instruction word width and instruction memory address width
//   CMD_WRITE        : command code for a single-word write
//   CMD_BURST        : command code for an auto-incrementing multi-word write
//   loader_state_t   : state encoding of the SPI instruction loader
//   cmd_writes()     : true when a command produces regfile writes
// -----------------------------------------------------------------------------
package pio_pkg;

   localparam int INSTR_W  = 16;
   localparam int ADDR_W   = 5;
   localparam int CMD_W    = 3;
   localparam int CMD_BITS = 8;   // command byte = {cmd[2:0], addr[4:0]}

   localparam logic [CMD_W-1:0] CMD_WRITE = 3'b001;
   localparam logic [CMD_W-1:0] CMD_BURST = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DONE
   } loader_state_t;

   // burst_en is a build-time constant; with it clear, CMD_BURST is a NOP.
   function automatic logic cmd_writes(input logic [CMD_W-1:0] cmd,
                                       input logic             burst_en);
      return (cmd == CMD_WRITE) || (burst_en && (cmd == CMD_BURST));
   endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Brings one asynchronous SPI pin into the clk domain: two synchroniser
// flops followed by a delay flop used for edge detection.
// Ports:
//   clk   : system clock
//   din   : raw asynchronous input
//   level : synchronised level
//   rise  : one-cycle pulse on a synchronised 0->1 transition
//   fall  : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync (
   input  logic clk,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   // NOTE: these flops are deliberately not reset. They keep tracking the pin
   // while rst is high, so a chip select that is already low when rst drops
   // is not mistaken for a fresh falling edge (the rest of that frame must be
   // ignored). Non-blocking assignments keep the three stages a true pipeline.
   always_ff @(posedge clk) begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
   end

   assign level = sync_q;
   assign rise  =  sync_q & ~dly_q;
   assign fall  = ~sync_q &  dly_q;

endmodule

// File: rtl/spi_instr_loader.sv
// -----------------------------------------------------------------------------
// spi_instr_loader
// Mode-0 SPI slave that receives instruction words from an off-chip host and
// drives the write port of the PIO instruction register file. Frame:
// command byte {cmd[2:0], addr[4:0]} then 16-bit data words, all MSB first.
// Build option: define SPI_INSTR_BURST_EN to enable the BURST command
// (auto-incrementing address); otherwise BURST decodes as NOP.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   spi_sclk   : SPI clock (async, idle low)
//   spi_cs_n   : SPI chip select (async, active low)
//   spi_mosi   : SPI data in, sampled on rising sclk
//   data_in    : word to write (valid with write_en, held afterwards)
//   write_addr : target address (valid with write_en, held afterwards)
//   write_en   : one-cycle write strobe
//   loading    : high while a frame is in progress
//   frame_err  : one-cycle pulse when a frame aborts mid-word
// -----------------------------------------------------------------------------
module spi_instr_loader #(
   parameter int INSTR_W = pio_pkg::INSTR_W,
   parameter int ADDR_W  = pio_pkg::ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spi_sclk,
   input  logic               spi_cs_n,
   input  logic               spi_mosi,
   output logic [INSTR_W-1:0] data_in,
   output logic [ADDR_W-1:0]  write_addr,
   output logic               write_en,
   output logic               loading,
   output logic               frame_err
);

   import pio_pkg::*;

   localparam int CNT_W = $clog2(INSTR_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(INSTR_W - 1);

`ifdef SPI_INSTR_BURST_EN
   localparam logic BURST_EN = 1'b1;
`else
   localparam logic BURST_EN = 1'b0;
`endif

   // ---------------------------------------------------------------- inputs
   logic sclk_rise;
   logic sclk_level_unused, sclk_fall_unused;
   logic cs_n_s, cs_rise, cs_fall;
   logic mosi_s;
   logic mosi_rise_unused, mosi_fall_unused;

   spi_sync u_sync_sclk (
      .clk   (clk),
      .din   (spi_sclk),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall_unused)
   );

   spi_sync u_sync_cs_n (
      .clk   (clk),
      .din   (spi_cs_n),
      .level (cs_n_s),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync u_sync_mosi (
      .clk   (clk),
      .din   (spi_mosi),
      .level (mosi_s),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   // ----------------------------------------------------------------- state
   loader_state_t      state_q,      state_d;
   logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
   logic [INSTR_W-1:0] shift_q,      shift_d;
   logic [CMD_W-1:0]   cmd_q,        cmd_d;
   logic [ADDR_W-1:0]  addr_q,       addr_d;
   logic [INSTR_W-1:0] data_in_q,    data_in_d;
   logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
   logic               write_en_q,   write_en_d;
   logic               loading_q,    loading_d;
   logic               frame_err_q,  frame_err_d;

   logic               sclk_tick;
   logic [INSTR_W-1:0] shift_nxt;

   assign sclk_tick = sclk_rise & ~cs_n_s;
   assign shift_nxt = {shift_q[INSTR_W-2:0], mosi_s};

   always_comb begin
      // NOTE: every variable gets a default here so no path can infer a latch.
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      data_in_d    = data_in_q;
      write_addr_d = write_addr_q;
      write_en_d   = 1'b0;
      loading_d    = loading_q;
      frame_err_d  = 1'b0;

      if (cs_rise) begin
         // End of frame from any state; only a partial byte/word is an error.
         state_d     = IDLE;
         bit_cnt_d   = '0;
         loading_d   = 1'b0;
         frame_err_d = ((state_q == CMD) || (state_q == DATA)) && (bit_cnt_q != '0);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = CMD;
                  bit_cnt_d = '0;
                  loading_d = 1'b1;
               end
            end

            CMD: begin
               if (sclk_tick) begin
                  shift_d = shift_nxt;
                  if (bit_cnt_q == CMD_LAST) begin
                     cmd_d     = shift_nxt[CMD_BITS-1 -: CMD_W];
                     addr_d    = shift_nxt[ADDR_W-1:0];
                     bit_cnt_d = '0;
                     state_d   = DATA;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end

            DATA: begin
               if (sclk_tick) begin
                  shift_d = shift_nxt;
                  if (bit_cnt_q == WORD_LAST) begin
                     bit_cnt_d = '0;
                     if (cmd_writes(cmd_q, BURST_EN)) begin
                        write_en_d   = 1'b1;
                        data_in_d    = shift_nxt;
                        write_addr_d = addr_q;
                     end
`ifdef SPI_INSTR_BURST_EN
                     if (cmd_q == CMD_BURST) begin
                        addr_d = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                     end else begin
                        state_d = DONE;
                     end
`else
                     state_d = DONE;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end

            DONE: begin
               // Trailing sclk edges are ignored until chip select rises.
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         data_in_q    <= '0;
         write_addr_q <= '0;
         write_en_q   <= 1'b0;
         loading_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         data_in_q    <= data_in_d;
         write_addr_q <= write_addr_d;
         write_en_q   <= write_en_d;
         loading_q    <= loading_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data_in    = data_in_q;
   assign write_addr = write_addr_q;
   assign write_en   = write_en_q;
   assign loading    = loading_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_instr_loader
// Directed bench for spi_instr_loader. The stimulus thread drives SPI frames,
// pushes expected writes into a scoreboard queue and posts level checks; a
// monitor on the falling clk edge pops and compares whenever write_en fires.
// -----------------------------------------------------------------------------
module tb_spi_instr_loader;

   import pio_pkg::*;

   logic               clk      = 1'b0;
   logic               rst      = 1'b1;
   logic               spi_sclk = 1'b0;
   logic               spi_cs_n = 1'b1;
   logic               spi_mosi = 1'b0;
   logic [INSTR_W-1:0] data_in;
   logic [ADDR_W-1:0]  write_addr;
   logic               write_en;
   logic               loading;
   logic               frame_err;

   always #5 clk = ~clk;

   spi_instr_loader #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .data_in    (data_in),
      .write_addr (write_addr),
      .write_en   (write_en),
      .loading    (loading),
      .frame_err  (frame_err)
   );

   // ------------------------------------------------------------ scoreboard
   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] data;
   } wr_t;

   typedef struct {
      string       name;
      int unsigned act;
      int unsigned exp;
   } chk_t;

   wr_t  exp_wr_q[$];
   chk_t chk_q[$];

   int   total    = 0;
   int   bad      = 0;
   int   wr_seen  = 0;
   int   err_seen = 0;
   int   wr_exp   = 0;
   int   err_exp  = 0;
   logic wen_prev = 1'b0;

   task automatic compare(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic post(input string name, input int unsigned act, input int unsigned exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_wr_q.push_back(w);
      wr_exp++;
   endtask

   // Monitor: the only process that compares and counts.
   always @(negedge clk) begin
      if (!rst && write_en) begin
         if (exp_wr_q.size() == 0) begin
            compare("unexpected_write_addr", 32'(write_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            compare("write_addr", 32'(write_addr), 32'(e.addr));
            compare("data_in",    32'(data_in),    32'(e.data));
         end
         compare("write_en_width", 32'(wen_prev), 32'd0);
         wr_seen++;
      end
      if (frame_err) err_seen++;
      wen_prev = write_en;
      while (chk_q.size() != 0) begin
         chk_t c;
         c = chk_q.pop_front();
         compare(c.name, c.act, c.exp);
      end
   end

   // ------------------------------------------------------------ SPI driver
   task automatic spi_bits(input logic [15:0] v, input int n, input int half);
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = v[i];
         #(half) spi_sclk = 1'b1;
         #(half) spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_begin(input int half);
      spi_cs_n = 1'b0;
      #(half);
   endtask

   task automatic cs_end(input int half);
      #(half) spi_cs_n = 1'b1;
      #(80);
   endtask

   task automatic frame(input logic [2:0] cmd, input logic [4:0] addr,
                        input logic [15:0] word, input int half);
      cs_begin(half);
      spi_bits({8'h00, cmd, addr}, 8, half);
      spi_bits(word, 16, half);
      cs_end(half);
   endtask

   task automatic post_counts(input string tag);
      post({tag, "_writes"}, 32'(wr_seen), 32'(wr_exp));
      post({tag, "_errs"},   32'(err_seen), 32'(err_exp));
   endtask

   // Watchdog: a hung run must still report.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      logic [15:0] w;

      // Reset state
      repeat (4) @(negedge clk);
      post("rst_data_in",    32'(data_in),    32'd0);
      post("rst_write_addr", 32'(write_addr), 32'd0);
      post("rst_write_en",   32'(write_en),   32'd0);
      post("rst_loading",    32'(loading),    32'd0);
      post("rst_frame_err",  32'(frame_err),  32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // WRITE addr 5, 16'hA5C3, loading observed during and after the frame
      expect_write(5'd5, 16'hA5C3);
      cs_begin(40);
      spi_bits({8'h00, 3'b001, 5'd5}, 8, 40);
      post("write_loading_hi", 32'(loading), 32'd1);
      spi_bits(16'hA5C3, 16, 40);
      post("write_loading_hi_end", 32'(loading), 32'd1);
      cs_end(40);
      post("write_loading_lo", 32'(loading), 32'd0);
      post_counts("write");

      // BURST from addr 30: 30, 31, 0 (no writes when BURST is compiled out)
`ifdef SPI_INSTR_BURST_EN
      expect_write(5'd30, 16'h0001);
      expect_write(5'd31, 16'h0002);
      expect_write(5'd0,  16'h0003);
`endif
      cs_begin(40);
      spi_bits({8'h00, 3'b010, 5'd30}, 8, 40);
      spi_bits(16'h0001, 16, 40);
      spi_bits(16'h0002, 16, 40);
      spi_bits(16'h0003, 16, 40);
      cs_end(40);
      post_counts("burst");

      // Abort after 9 data bits, then a good WRITE to addr 2
      cs_begin(40);
      spi_bits({8'h00, 3'b001, 5'd7}, 8, 40);
      spi_bits(16'h01AB, 9, 40);
      cs_end(40);
      err_exp++;
      post_counts("abort");
      expect_write(5'd2, 16'h1234);
      frame(3'b001, 5'd2, 16'h1234, 40);
      post_counts("after_abort");

      // NOP command 3'b111 with one data word
      frame(3'b111, 5'd9, 16'hFFFF, 40);
      post_counts("nop");

      // Reset after 10 bits of a WRITE frame, released with cs_n still low
      w = 16'hDEAD;
      cs_begin(40);
      spi_bits({8'h00, 3'b001, 5'd12}, 8, 40);
      spi_bits({14'd0, w[15:14]}, 2, 40);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      post("midrst_data_in",    32'(data_in),    32'd0);
      post("midrst_write_addr", 32'(write_addr), 32'd0);
      post("midrst_loading",    32'(loading),    32'd0);
      rst = 1'b0;
      spi_bits({2'd0, w[13:0]}, 14, 40);
      cs_end(40);
      post_counts("midrst");
      expect_write(5'd12, 16'h0BAD);
      frame(3'b001, 5'd12, 16'h0BAD, 40);
      post_counts("after_midrst");

      // Minimum clock ratio: sclk period = 4 clk, back-to-back frames
      expect_write(5'd0,  16'hBEEF);
      expect_write(5'd31, 16'h0F0F);
      frame(3'b001, 5'd0,  16'hBEEF, 20);
      frame(3'b001, 5'd31, 16'h0F0F, 20);
      repeat (4) @(negedge clk);
      post_counts("min_ratio");
      post("held_data_in",    32'(data_in),    32'h0F0F);
      post("held_write_addr", 32'(write_addr), 32'd31);
      post("scoreboard_empty", 32'(exp_wr_q.size()), 32'd0);

      // Let the monitor drain the posted checks
      for (int i = 0; i < 10 && chk_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (chk_q.size() != 0) begin
         $display("FAIL drain: %0d checks never compared", chk_q.size());
         $fatal(1, "drain");
      end
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
